// File: rtl/cart_mem_arbiter.sv
// Cartridge memory arbiter: serialises PPU, CPU and loader requests onto one
// single-port memory, with CPU anti-starvation and sticky overflow flags.
module cart_mem_arbiter #(
  parameter int ADDR_W     = 18,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk_25,
  input  logic              rst,
  input  logic              ppu_stb,
  input  logic              ppu_we,
  input  logic [ADDR_W-1:0] ppu_addr,
  input  logic [7:0]        ppu_wdata,
  output logic              ppu_ack,
  input  logic              cpu_stb,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_wdata,
  output logic              cpu_ack,
  input  logic              ldr_stb,
  input  logic              ldr_we,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [7:0]        ldr_wdata,
  output logic              ldr_ack,
  output logic [7:0]        rdata,
  output logic              mem_ce,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic [2:0]        err_ovf
);

  localparam logic [1:0] P_PPU = 2'd0;
  localparam logic [1:0] P_CPU = 2'd1;
  localparam logic [1:0] P_LDR = 2'd2;
  localparam logic [2:0] LAT_LAST   = 3'(MEM_LAT - 1);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE = 2'd0, ACC = 2'd1, DONE = 2'd2} state_t;

  logic [2:0]             stb_v, we_v;
  logic [2:0][ADDR_W-1:0] addr_v;
  logic [2:0][7:0]        wdata_v;

  assign stb_v   = {ldr_stb, cpu_stb, ppu_stb};
  assign we_v    = {ldr_we, cpu_we, ppu_we};
  assign addr_v  = {ldr_addr, cpu_addr, ppu_addr};
  assign wdata_v = {ldr_wdata, cpu_wdata, ppu_wdata};

  logic [2:0]             pend, slot_we;
  logic [2:0][ADDR_W-1:0] slot_addr;
  logic [2:0][7:0]        slot_wdata;

  state_t      state;
  logic [2:0]  cnt;
  logic [1:0]  owner, win;
  logic [3:0]  starve_cnt;
  logic [2:0]  ack;
  logic [2:0]  req;
  logic        acc_last;
  logic        sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [7:0]  sel_wdata;

  // A strobe arriving while the FSM sits in IDLE is granted in that same cycle,
  // so arbitration sees the live strobes as well as the latched slots.
  assign req      = pend | stb_v;
  assign acc_last = (state == ACC) && (cnt == LAT_LAST);

  // NOTE: every output of an always_comb gets a default first so no latch is inferred.
  always_comb begin
    win = P_PPU;
    if (req[P_CPU] && (starve_cnt >= STARVE_LIM)) win = P_CPU;
    else if (req[P_PPU])                          win = P_PPU;
    else if (req[P_CPU])                          win = P_CPU;
    else if (req[P_LDR])                          win = P_LDR;

    sel_we    = we_v[win];
    sel_addr  = addr_v[win];
    sel_wdata = wdata_v[win];
    if (pend[win]) begin
      sel_we    = slot_we[win];
      sel_addr  = slot_addr[win];
      sel_wdata = slot_wdata[win];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_25 or posedge rst) begin
    if (rst) begin
      pend       <= '0;
      err_ovf    <= '0;
      slot_we    <= '0;
      slot_addr  <= '0;
      slot_wdata <= '0;
    end else begin
      for (int p = 0; p < 3; p++) begin
        if (stb_v[p] && pend[p]) err_ovf[p] <= 1'b1;
        if (stb_v[p] && !pend[p]) begin
          pend[p]       <= 1'b1;
          slot_we[p]    <= we_v[p];
          slot_addr[p]  <= addr_v[p];
          slot_wdata[p] <= wdata_v[p];
        end else if (acc_last && (owner == 2'(p))) begin
          pend[p] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_25 or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      owner      <= P_PPU;
      starve_cnt <= '0;
      ack        <= '0;
      mem_ce     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      rdata      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            owner     <= win;
            mem_ce    <= 1'b1;
            mem_we    <= sel_we;
            mem_addr  <= sel_addr;
            mem_wdata <= sel_wdata;
            cnt       <= '0;
            state     <= ACC;
            if ((win == P_PPU) && req[P_CPU])
              starve_cnt <= (starve_cnt == 4'hF) ? starve_cnt : starve_cnt + 4'd1;
            else
              starve_cnt <= '0;
          end else begin
            starve_cnt <= '0;
          end
        end
        ACC: begin
          if (acc_last) begin
            if (!mem_we) rdata <= mem_rdata;
            mem_ce     <= 1'b0;
            mem_we     <= 1'b0;
            ack[owner] <= 1'b1;
            state      <= DONE;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        DONE: begin
          ack   <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ppu_ack = ack[0];
  assign cpu_ack = ack[1];
  assign ldr_ack = ack[2];

endmodule

// File: tb/tb_cart_mem_arbiter.sv
// Bench for cart_mem_arbiter: two instances (MEM_LAT 1 and 3) checked every cycle
// against a timestamp-based transaction model, plus hand-computed directed checks.
module tb_cart_mem_arbiter;

  localparam int AW   = 18;
  localparam int SMAX = 3;

  logic clk_25 = 1'b0;
  logic rst    = 1'b1;
  always #20 clk_25 = ~clk_25;

  logic [2:0]    stb [2];
  logic [2:0]    we  [2];
  logic [AW-1:0] addr [2][3];
  logic [7:0]    wd   [2][3];

  wire           ce_w   [2];
  wire           mwe_w  [2];
  wire [AW-1:0]  maddr_w[2];
  wire [7:0]     mwd_w  [2];
  wire [7:0]     rd_w   [2];
  wire [2:0]     ack_w  [2];
  wire [2:0]     err_w  [2];

  int n_chk  = 0;
  int n_pass = 0;

  function automatic logic [7:0] pat(input logic [AW-1:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  // Instance 0 runs with MEM_LAT=1, instance 1 with MEM_LAT=3; each has its own memory.
  for (genvar k = 0; k < 2; k++) begin : g_dut
    logic [7:0] mrd = 8'h00;
    logic [7:0] bmem [int];

    cart_mem_arbiter #(.ADDR_W(AW), .MEM_LAT(k == 0 ? 1 : 3), .STARVE_MAX(SMAX)) u_dut (
      .clk_25   (clk_25),
      .rst      (rst),
      .ppu_stb  (stb[k][0]),
      .ppu_we   (we[k][0]),
      .ppu_addr (addr[k][0]),
      .ppu_wdata(wd[k][0]),
      .ppu_ack  (ack_w[k][0]),
      .cpu_stb  (stb[k][1]),
      .cpu_we   (we[k][1]),
      .cpu_addr (addr[k][1]),
      .cpu_wdata(wd[k][1]),
      .cpu_ack  (ack_w[k][1]),
      .ldr_stb  (stb[k][2]),
      .ldr_we   (we[k][2]),
      .ldr_addr (addr[k][2]),
      .ldr_wdata(wd[k][2]),
      .ldr_ack  (ack_w[k][2]),
      .rdata    (rd_w[k]),
      .mem_ce   (ce_w[k]),
      .mem_we   (mwe_w[k]),
      .mem_addr (maddr_w[k]),
      .mem_wdata(mwd_w[k]),
      .mem_rdata(mrd),
      .err_ovf  (err_w[k])
    );

    initial forever begin
      @(posedge clk_25);
      if (ce_w[k] && mwe_w[k]) bmem[int'(maddr_w[k])] = mwd_w[k];
    end

    initial forever begin
      @(negedge clk_25);
      mrd = bmem.exists(int'(maddr_w[k])) ? bmem[int'(maddr_w[k])] : pat(maddr_w[k]);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  // ---------------- transaction model ----------------
  // Each grant is recorded as timestamps: enable window, ack cycle, next free cycle.
  int            cyc = 0;
  logic [2:0]    m_pend [2], m_err [2];
  logic          m_swe [2][3];
  logic [AW-1:0] m_sa  [2][3];
  logic [7:0]    m_sd  [2][3];
  int            m_starve [2], m_owner [2], m_from [2], m_to [2], m_ackc [2], m_free [2];
  logic          m_cwe [2];
  logic [AW-1:0] m_ca  [2];
  logic [7:0]    m_cd  [2], m_nrd [2], m_rd [2];
  logic [7:0]    sh [int];

  function automatic int sh_key(input int k, input logic [AW-1:0] a);
    return k * (1 << AW) + int'(a);
  endfunction

  task automatic model_reset(input int k);
    m_pend[k] = '0; m_err[k] = '0; m_starve[k] = 0; m_owner[k] = 0;
    m_from[k] = 1; m_to[k] = 0; m_ackc[k] = -1; m_free[k] = 0;
    m_cwe[k] = 1'b0; m_ca[k] = '0; m_cd[k] = '0; m_nrd[k] = '0; m_rd[k] = '0;
  endtask

  task automatic model_step(input int k);
    int t, w, lat, key;
    logic [2:0] req, acc;
    t   = cyc;
    lat = (k == 0) ? 1 : 3;
    req = m_pend[k] | stb[k];
    acc = stb[k] & ~m_pend[k];
    m_err[k] = m_err[k] | (stb[k] & m_pend[k]);
    if (t >= m_free[k]) begin
      if (req != 3'b000) begin
        if (req[1] && m_starve[k] >= SMAX) w = 1;
        else if (req[0]) w = 0;
        else if (req[1]) w = 1;
        else w = 2;
        m_starve[k] = (w == 0 && req[1]) ? ((m_starve[k] < 15) ? m_starve[k] + 1 : 15) : 0;
        m_owner[k] = w;
        m_cwe[k] = m_pend[k][w] ? m_swe[k][w] : we[k][w];
        m_ca[k]  = m_pend[k][w] ? m_sa[k][w]  : addr[k][w];
        m_cd[k]  = m_pend[k][w] ? m_sd[k][w]  : wd[k][w];
        m_from[k] = t + 1;
        m_to[k]   = t + lat;
        m_ackc[k] = t + lat + 1;
        m_free[k] = t + lat + 2;
        key = sh_key(k, m_ca[k]);
        if (m_cwe[k]) sh[key] = m_cd[k];
        else m_nrd[k] = sh.exists(key) ? sh[key] : pat(m_ca[k]);
      end else begin
        m_starve[k] = 0;
      end
    end
    for (int p = 0; p < 3; p++) begin
      if (acc[p]) begin
        m_pend[k][p] = 1'b1;
        m_swe[k][p]  = we[k][p];
        m_sa[k][p]   = addr[k][p];
        m_sd[k][p]   = wd[k][p];
      end
    end
    if (t + 1 == m_ackc[k]) begin
      m_pend[k][m_owner[k]] = 1'b0;
      if (!m_cwe[k]) m_rd[k] = m_nrd[k];
    end
  endtask

  initial forever begin
    @(posedge clk_25 or posedge rst);
    if (rst) begin
      model_reset(0);
      model_reset(1);
    end else begin
      model_step(0);
      model_step(1);
      cyc = cyc + 1;
    end
  end

  // Per-cycle comparison of both instances against the model.
  initial forever begin
    @(negedge clk_25);
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        check($sformatf("i%0d_rst_ce", k),  32'(ce_w[k]),  32'h0);
        check($sformatf("i%0d_rst_ack", k), 32'(ack_w[k]), 32'h0);
        check($sformatf("i%0d_rst_err", k), 32'(err_w[k]), 32'h0);
      end else begin
        logic exp_ce;
        logic [2:0] exp_ack;
        exp_ce  = (cyc >= m_from[k]) && (cyc <= m_to[k]);
        exp_ack = (cyc == m_ackc[k]) ? (3'b001 << m_owner[k]) : 3'b000;
        check($sformatf("i%0d_ce@%0d", k, cyc),  32'(ce_w[k]),  32'(exp_ce));
        check($sformatf("i%0d_we@%0d", k, cyc),  32'(mwe_w[k]), 32'(exp_ce && m_cwe[k]));
        if (exp_ce) check($sformatf("i%0d_addr@%0d", k, cyc), 32'(maddr_w[k]), 32'(m_ca[k]));
        if (exp_ce && m_cwe[k]) check($sformatf("i%0d_wdata@%0d", k, cyc), 32'(mwd_w[k]), 32'(m_cd[k]));
        check($sformatf("i%0d_ack@%0d", k, cyc),   32'(ack_w[k]), 32'(exp_ack));
        check($sformatf("i%0d_rdata@%0d", k, cyc), 32'(rd_w[k]),  32'(m_rd[k]));
        check($sformatf("i%0d_err@%0d", k, cyc),   32'(err_w[k]), 32'(m_err[k]));
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk_25);
    #1;
  endtask

  task automatic strobe(input int k, input int p, input logic w,
                        input logic [AW-1:0] a, input logic [7:0] d);
    stb[k][p]  = 1'b1;
    we[k][p]   = w;
    addr[k][p] = a;
    wd[k][p]   = d;
  endtask

  task automatic idle();
    stb[0] = 3'b000;
    stb[1] = 3'b000;
  endtask

  initial begin
    int at [3];
    int n_ppu, n_cpu;
    logic cpu_seen;

    for (int k = 0; k < 2; k++) begin
      stb[k] = '0;
      we[k]  = '0;
      for (int p = 0; p < 3; p++) begin
        addr[k][p] = '0;
        wd[k][p]   = '0;
      end
    end

    repeat (3) @(posedge clk_25);
    #1;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("reset_ce_%0d", k),    32'(ce_w[k]),    32'h0);
      check($sformatf("reset_addr_%0d", k),  32'(maddr_w[k]), 32'h0);
      check($sformatf("reset_rdata_%0d", k), 32'(rd_w[k]),    32'h0);
    end
    rst = 1'b0;
    repeat (2) tick();

    // 1: single PPU read, MEM_LAT=1
    strobe(0, 0, 1'b0, 18'h01234, 8'h00);
    tick(); idle();
    check("t1_ce",    32'(ce_w[0]),    32'h1);
    check("t1_addr",  32'(maddr_w[0]), 32'h01234);
    tick();
    check("t1_ack",   32'(ack_w[0]),   32'b001);
    check("t1_rdata", 32'(rd_w[0]),    32'h7C);
    repeat (3) tick();

    // 2: all three strobe together -> PPU, CPU, LDR, acks 3 cycles apart
    strobe(0, 0, 1'b0, 18'h00100, 8'h00);
    strobe(0, 1, 1'b0, 18'h00200, 8'h00);
    strobe(0, 2, 1'b0, 18'h00300, 8'h00);
    at = '{-1, -1, -1};
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (i == 1) idle();
      for (int p = 0; p < 3; p++) if (ack_w[0][p]) at[p] = i;
    end
    check("t2_ppu_ack_cyc", 32'(at[0]), 32'd2);
    check("t2_cpu_ack_cyc", 32'(at[1]), 32'd5);
    check("t2_ldr_ack_cyc", 32'(at[2]), 32'd8);

    // 3: CPU starvation bound, PPU re-strobed in each of its ack cycles
    strobe(0, 0, 1'b0, 18'h00010, 8'h00);
    strobe(0, 1, 1'b0, 18'h00020, 8'h00);
    n_ppu = 0;
    cpu_seen = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      idle();
      if (ack_w[0][1]) cpu_seen = 1'b1;
      if (cpu_seen) break;
      if (ack_w[0][0]) begin
        n_ppu++;
        if (n_ppu <= 3) strobe(0, 0, 1'b0, 18'(32'h10 + n_ppu), 8'h00);
      end
    end
    idle();
    check("t3_cpu_acked",        32'(cpu_seen), 32'h1);
    check("t3_ppu_acks_before",  32'(n_ppu),    32'd3);
    repeat (8) tick();
    check("t3_no_err", 32'(err_w[0]), 32'b000);

    // 4: second CPU strobe while pending is dropped and flagged
    strobe(0, 1, 1'b0, 18'h00040, 8'h00);
    n_cpu = 0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i == 1) strobe(0, 1, 1'b0, 18'h00041, 8'h00);
      else idle();
      if (ack_w[0][1]) n_cpu++;
    end
    check("t4_single_ack", 32'(n_cpu),    32'd1);
    check("t4_err",        32'(err_w[0]), 32'b010);
    repeat (3) tick();
    check("t4_err_sticky", 32'(err_w[0]), 32'b010);

    // 5: loader write then read back, MEM_LAT=3
    strobe(1, 2, 1'b1, 18'h3FFFF, 8'hA5);
    at[2] = -1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (i == 1) idle();
      if (ack_w[1][2]) begin
        at[2] = i;
        check("t5_rdata_on_write", 32'(rd_w[1]), 32'h00);
      end
    end
    check("t5_write_ack_cyc", 32'(at[2]), 32'd4);
    strobe(1, 2, 1'b0, 18'h3FFFF, 8'h00);
    at[2] = -1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (i == 1) idle();
      if (ack_w[1][2]) begin
        at[2] = i;
        check("t5_readback", 32'(rd_w[1]), 32'hA5);
      end
    end
    check("t5_read_ack_cyc", 32'(at[2]), 32'd4);

    // 6: reset during an access abandons it
    strobe(1, 1, 1'b0, 18'h00055, 8'h00);
    tick(); idle();
    tick();
    check("t6_ce_before_rst", 32'(ce_w[1]), 32'h1);
    #5 rst = 1'b1;
    #1;
    check("t6_ce_drops",   32'(ce_w[1]),  32'h0);
    check("t6_we_drops",   32'(mwe_w[1]), 32'h0);
    check("t6_err_clears", 32'(err_w[0]), 32'b000);
    repeat (2) @(posedge clk_25);
    #1 rst = 1'b0;
    repeat (2) tick();
    strobe(1, 2, 1'b0, 18'h00077, 8'h00);
    at = '{-1, -1, -1};
    n_cpu = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i == 1) idle();
      if (ack_w[1][2] && at[2] < 0) at[2] = i;
      if (ack_w[1][1]) n_cpu++;
    end
    check("t6_ldr_ack_cyc",  32'(at[2]), 32'd4);
    check("t6_no_cpu_ack",   32'(n_cpu), 32'd0);

    repeat (4) tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
